pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage CPU. Combinationally drives the `en`/`clr_n` pair of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC write enable. It resolves load-use hazards, taken-branch flushes and data-memory wait states. A wait-timeout watchdog halts the pipeline on a hung memory, and a saturating counter records stall cycles for performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: drives en/clr_n of every pipeline
// register and the PC enable, with a memory-wait watchdog and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Id_Rs,
    input  logic [4:0]       Id_Rt,
    input  logic             Id_UsesRt,
    input  logic [4:0]       Ex_Rd,
    input  logic             Ex_Wreg,
    input  logic             Ex_Reg2reg,
    input  logic             Branch_Taken,
    input  logic             Mem_Req,
    input  logic             Mem_Ack,
    output logic             Pc_En,
    output logic             IfId_En,
    output logic             IfId_Clr_n,
    output logic             IdEx_En,
    output logic             IdEx_Clr_n,
    output logic             ExMem_En,
    output logic             ExMem_Clr_n,
    output logic             MemWb_En,
    output logic             MemWb_Clr_n,
    output logic             Mem_Err,
    output logic [CNT_W-1:0] Stall_Cnt
);
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic              mw, lu, br;

    always_comb begin
        mw = Mem_Req & ~Mem_Ack;
        lu = Ex_Reg2reg & Ex_Wreg & (Ex_Rd != 5'd0) &
             ((Ex_Rd == Id_Rs) | (Id_UsesRt & (Ex_Rd == Id_Rt)));
        br = Branch_Taken;
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        mem_err_d   = mem_err_q;
        if (!mw) begin
            wait_cnt_d = '0;
        end
        if (state_q == RUN) begin
            if (mw) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // The TIMEOUT-th consecutive wait cycle moves us to HALT.
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = HALT;
                    mem_err_d = 1'b1;
                end
            end
            if ((mw | (lu & ~br)) && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign Mem_Err   = mem_err_q;
    assign Stall_Cnt = stall_cnt_q;

    // Priority: reset, halt, memory wait, branch flush, load-use bubble.
    always_comb begin
        Pc_En       = 1'b1;
        IfId_En     = 1'b1;
        IfId_Clr_n  = 1'b1;
        IdEx_En     = 1'b1;
        IdEx_Clr_n  = 1'b1;
        ExMem_En    = 1'b1;
        ExMem_Clr_n = 1'b1;
        MemWb_En    = 1'b1;
        MemWb_Clr_n = 1'b1;
        if (!rst_n) begin
            Pc_En       = 1'b0;
            IfId_Clr_n  = 1'b0;
            IdEx_Clr_n  = 1'b0;
            ExMem_Clr_n = 1'b0;
            MemWb_Clr_n = 1'b0;
        end else if (state_q == HALT) begin
            Pc_En    = 1'b0;
            IfId_En  = 1'b0;
            IdEx_En  = 1'b0;
            ExMem_En = 1'b0;
            MemWb_En = 1'b0;
        end else if (mw) begin
            Pc_En       = 1'b0;
            IfId_En     = 1'b0;
            IdEx_En     = 1'b0;
            ExMem_En    = 1'b0;
            MemWb_Clr_n = 1'b0;
        end else if (br) begin
            IfId_Clr_n = 1'b0;
            IdEx_Clr_n = 1'b0;
        end else if (lu) begin
            Pc_En      = 1'b0;
            IfId_En    = 1'b0;
            IdEx_Clr_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (TIMEOUT=16/CNT_W=16 and TIMEOUT=32/CNT_W=4)
// share inputs and are compared each cycle against a rule-table reference model.
module tb_pipe_hazard_ctrl;
    logic       clk, rst_n;
    logic [4:0] Id_Rs, Id_Rt, Ex_Rd;
    logic       Id_UsesRt, Ex_Wreg, Ex_Reg2reg, Branch_Taken, Mem_Req, Mem_Ack;

    logic        pc_a, ife_a, ifc_a, ide_a, idc_a, exe_a, exc_a, mwe_a, mwc_a, err_a;
    logic        pc_b, ife_b, ifc_b, ide_b, idc_b, exe_b, exc_b, mwe_b, mwc_b, err_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [8:0]  ctrl_a, ctrl_b;

    assign ctrl_a = {pc_a, ife_a, ifc_a, ide_a, idc_a, exe_a, exc_a, mwe_a, mwc_a};
    assign ctrl_b = {pc_b, ife_b, ifc_b, ide_b, idc_b, exe_b, exc_b, mwe_b, mwc_b};

    pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .Id_Rs(Id_Rs), .Id_Rt(Id_Rt), .Id_UsesRt(Id_UsesRt),
        .Ex_Rd(Ex_Rd), .Ex_Wreg(Ex_Wreg), .Ex_Reg2reg(Ex_Reg2reg),
        .Branch_Taken(Branch_Taken), .Mem_Req(Mem_Req), .Mem_Ack(Mem_Ack),
        .Pc_En(pc_a), .IfId_En(ife_a), .IfId_Clr_n(ifc_a), .IdEx_En(ide_a),
        .IdEx_Clr_n(idc_a), .ExMem_En(exe_a), .ExMem_Clr_n(exc_a), .MemWb_En(mwe_a),
        .MemWb_Clr_n(mwc_a), .Mem_Err(err_a), .Stall_Cnt(cnt_a));

    pipe_hazard_ctrl #(.TIMEOUT(32), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .Id_Rs(Id_Rs), .Id_Rt(Id_Rt), .Id_UsesRt(Id_UsesRt),
        .Ex_Rd(Ex_Rd), .Ex_Wreg(Ex_Wreg), .Ex_Reg2reg(Ex_Reg2reg),
        .Branch_Taken(Branch_Taken), .Mem_Req(Mem_Req), .Mem_Ack(Mem_Ack),
        .Pc_En(pc_b), .IfId_En(ife_b), .IfId_Clr_n(ifc_b), .IdEx_En(ide_b),
        .IdEx_Clr_n(idc_b), .ExMem_En(exe_b), .ExMem_Clr_n(exc_b), .MemWb_En(mwe_b),
        .MemWb_Clr_n(mwc_b), .Mem_Err(err_b), .Stall_Cnt(cnt_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int n_tests = 0;
    int n_fail  = 0;
    int timeout_lim[2] = '{16, 32};
    int cnt_max[2]     = '{65535, 15};
    int halted[2];
    int consec[2];
    int stalls[2];

    function automatic bit m_mw();
        return Mem_Req && !Mem_Ack;
    endfunction

    function automatic bit m_lu();
        return Ex_Reg2reg && Ex_Wreg && (Ex_Rd != 0) &&
               ((Ex_Rd == Id_Rs) || (Id_UsesRt && (Ex_Rd == Id_Rt)));
    endfunction

    // Expected {Pc, IfId en/clr, IdEx en/clr, ExMem en/clr, MemWb en/clr} from the rule table.
    function automatic logic [8:0] exp_ctrl(int h);
        if (!rst_n)     return 9'b0_10_10_10_10;
        if (h != 0)     return 9'b0_01_01_01_01;
        if (m_mw())     return 9'b0_01_01_01_10;
        if (Branch_Taken) return 9'b1_10_10_11_11;
        if (m_lu())     return 9'b0_01_10_11_11;
        return 9'b1_11_11_11_11;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            halted[i] = 0;
            consec[i] = 0;
            stalls[i] = 0;
        end
    endtask

    task automatic model_clock();
        if (!rst_n) return;
        for (int i = 0; i < 2; i++) begin
            if (halted[i] == 0) begin
                if (m_mw() || (m_lu() && !Branch_Taken))
                    stalls[i] = (stalls[i] < cnt_max[i]) ? stalls[i] + 1 : stalls[i];
                if (m_mw()) begin
                    consec[i]++;
                    if (consec[i] == timeout_lim[i]) halted[i] = 1;
                end else begin
                    consec[i] = 0;
                end
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".ctrl_a"}, 32'(ctrl_a), 32'(exp_ctrl(halted[0])));
        check({tag, ".ctrl_b"}, 32'(ctrl_b), 32'(exp_ctrl(halted[1])));
        check({tag, ".cnt_a"},  32'(cnt_a),  32'(stalls[0]));
        check({tag, ".cnt_b"},  32'(cnt_b),  32'(stalls[1]));
        check({tag, ".err_a"},  32'(err_a),  32'(halted[0]));
        check({tag, ".err_b"},  32'(err_b),  32'(halted[1]));
    endtask

    // Inputs are driven just after a falling edge; check, then clock once.
    task automatic cyc(string tag);
        #1 check_all(tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_in(logic [4:0] rs, logic [4:0] rt, logic ut, logic [4:0] rd,
                          logic wr, logic ld, logic bt, logic rq, logic ak);
        Id_Rs = rs; Id_Rt = rt; Id_UsesRt = ut; Ex_Rd = rd; Ex_Wreg = wr;
        Ex_Reg2reg = ld; Branch_Taken = bt; Mem_Req = rq; Mem_Ack = ak;
    endtask

    // Asynchronous pulse off the clock edge, held across one rising edge.
    task automatic async_reset(string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all({tag, ".lo"});
        @(posedge clk);
        #2 check_all({tag, ".lo_edge"});
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check_all("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc("idle");

        set_in(5, 0, 0, 5, 1, 1, 0, 0, 0); cyc("lu");
        set_in(5, 0, 0, 5, 1, 0, 0, 0, 0); cyc("lu_after");
        set_in(0, 0, 0, 0, 1, 1, 0, 0, 0); cyc("lu_rd0");
        set_in(1, 5, 0, 5, 1, 1, 0, 0, 0); cyc("lu_rt_unused");
        set_in(1, 5, 1, 5, 1, 1, 0, 0, 0); cyc("lu_rt_used");
        set_in(5, 0, 0, 5, 1, 1, 1, 0, 0); cyc("br_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("idle2");

        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) cyc("mw");
        Mem_Ack = 1'b1; cyc("mw_ack");
        Mem_Req = 1'b0; cyc("mw_done");

        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        repeat (3) cyc("mw_br");
        Mem_Ack = 1'b1; cyc("mw_br_ack");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("idle3");

        // dut_a times out after 16 waits; dut_b keeps stalling and saturates.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (20) cyc("timeout");
        Mem_Ack = 1'b1;
        repeat (2) cyc("halt_ack");
        Mem_Ack = 1'b0;
        async_reset("rst_mid_wait");
        repeat (3) cyc("post_rst");

        for (int i = 0; i < 2400; i++) begin
            int ack_odds;
            ack_odds = ((i / 300) % 2 == 1) ? 7 : 1;
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) == 0), 1'($urandom),
                   1'($urandom_range(0, ack_odds) == 0));
            if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
